// File: rtl/sreg_pipeline_pkg.sv
// Shared defaults and the stage record for the handshaked shift-register pipeline.
package sreg_pipeline_pkg;

  localparam int SREG_WIDTH_DEF = 9;
  localparam int SREG_DEPTH_DEF = 4;

  // One pipeline slot at the default width; wider builds use the same {valid, data} shape.
  typedef struct packed {
    logic                      valid;
    logic [SREG_WIDTH_DEF-1:0] data;
  } sreg_stage_t;

endpackage

// File: rtl/sreg_pipeline_hs_if.sv
// Producer/consumer bundle of the pipeline: input handshake, output handshake, occupancy.
interface sreg_pipeline_hs_if
  import sreg_pipeline_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH_DEF,
  parameter int DEPTH = SREG_DEPTH_DEF
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // A word moves across either end on a rising edge where valid and ready are both 1;
  // the sender holds valid and data stable until that happens, ready may change freely.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/sreg_pipeline_stage.sv
// One pipeline slot: loads {valid, data} when told to, otherwise holds; flush drops valid.
module sreg_pipeline_stage
  import sreg_pipeline_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    // Data is left alone on flush; only the valid bit matters afterwards.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sreg_pipeline_hs.sv
// DEPTH-stage valid/ready shift pipeline with bubble collapse, global enable, flush and occupancy.
module sreg_pipeline_hs
  import sreg_pipeline_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH_DEF,
  parameter int DEPTH = SREG_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  sreg_pipeline_hs_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] load;
  logic [OCC_W-1:0] occ;
  logic             advance;

  assign advance = en && !flush;

  // A stage can take a new word if it is empty or its own word is moving on this edge.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !stg_valid[i] || rdy[i+1];
    end
  end

  assign load = {DEPTH{advance}} & rdy[DEPTH-1:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (g == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
    end else begin : g_body
      assign src_valid = stg_valid[g-1];
      assign src_data  = stg_data[g-1];
    end

    sreg_pipeline_stage #(.WIDTH(WIDTH)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .load_i  (load[g]),
      .flush_i (flush),
      .valid_i (src_valid),
      .data_i  (src_data),
      .valid_o (stg_valid[g]),
      .data_o  (stg_data[g])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(stg_valid[i]);
    end
  end

  // Reset gates in_ready so a producer never sees an acceptance while registers are held clear.
  assign bus.in_ready  = reset && advance && rdy[0];
  assign bus.out_valid = en && stg_valid[DEPTH-1];
  assign bus.out_data  = stg_data[DEPTH-1];
  assign bus.occupancy = occ;

endmodule
